// File: rtl/btn_ctrl_pkg.sv
// Shared definitions for the button arbiter: FSM state encoding, datapath
// and requester widths, default OFFSET/HOLD_CYC, and a one-hot helper.
package btn_ctrl_pkg;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned REQ_IDX_W    = 2;
    localparam int unsigned DATA_W       = 6;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned OFFSET_DEF   = 26;
    localparam int unsigned HOLD_CYC_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_e;

    // One-hot mask for a requester index.
    function automatic logic [NUM_REQ-1:0] onehot(input logic [REQ_IDX_W-1:0] idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arb4.sv
// Combinational 4-way round-robin pick: the first set pending bit found when
// scanning upward (with wrap) from the rr pointer wins.
module rr_arb4
    import btn_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0]   pending_i,
    input  logic [REQ_IDX_W-1:0] rr_i,
    output logic [REQ_IDX_W-1:0] winner_o,
    output logic                 valid_o
);

    // Scan the four positions starting at rr; the first requester found wins.
    always_comb begin : p_pick
        logic [REQ_IDX_W-1:0] idx;
        logic                 found;
        // NOTE: every variable gets a value before any branch, so no path
        // through this block can leave one unassigned and infer a latch.
        idx      = '0;
        found    = 1'b0;
        winner_o = rr_i;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr_i + REQ_IDX_W'(i);
            if (!found && pending_i[idx]) begin
                winner_o = idx;
                found    = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/btn_arb_ctrl.sv
// Button arbiter: rise-detects four request lines, serves them round-robin,
// toggles the winner's operand bit and shows OFFSET + operand on led for
// HOLD_CYC cycles before the next grant.
// Build option: define BTN_SYNC_EN to put a two-flop synchronizer on btn.
module btn_arb_ctrl
    import btn_ctrl_pkg::*;
#(
    parameter int unsigned OFFSET   = OFFSET_DEF,
    parameter int unsigned HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] btn,
    output logic [DATA_W-1:0]  led,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy
);

    localparam logic [DATA_W-1:0] OFFSET_C  = DATA_W'(OFFSET);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYC - 1);

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   btn_s;
    logic [NUM_REQ-1:0]   prev_q;
    logic [NUM_REQ-1:0]   rise;
    logic [NUM_REQ-1:0]   pending_q, pending_d, pending_clr;
    logic [NUM_REQ-1:0]   operand_q, operand_d;
    logic [REQ_IDX_W-1:0] rr_q, rr_d;
    logic [REQ_IDX_W-1:0] winner_q, winner_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]    led_q, led_d;
    logic [REQ_IDX_W-1:0] arb_winner;
    logic                 arb_valid;

    rr_arb4 u_arb (
        .pending_i (pending_q),
        .rr_i      (rr_q),
        .winner_o  (arb_winner),
        .valid_o   (arb_valid)
    );

    // Rising edge of each (optionally synchronized) request line.
    assign rise = btn_s & ~prev_q;

    // Next-state, arbitration side effects and grant decode.
    always_comb begin
        state_d     = state_q;
        pending_clr = '0;
        operand_d   = operand_q;
        rr_d        = rr_q;
        winner_d    = winner_q;
        cnt_d       = cnt_q;
        led_d       = led_q;
        grant       = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    pending_clr[arb_winner] = 1'b1;
                    operand_d[arb_winner]   = ~operand_q[arb_winner];
                    rr_d                    = arb_winner + REQ_IDX_W'(1);
                    winner_d                = arb_winner;
                    state_d                 = ADD;
                end
            end
            ADD: begin
                grant   = onehot(winner_q);
                // 6-bit add: the carry out is dropped, so the result wraps.
                led_d   = OFFSET_C + {{(DATA_W-NUM_REQ){1'b0}}, operand_q};
                cnt_d   = '0;
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // A fresh rise on the bit being cleared keeps it pending.
        pending_d = (pending_q & ~pending_clr) | rise;
    end

    // State register with synchronous reset; a reset edge discards any
    // in-flight ADD/HOLD work.
    always_ff @(posedge clk) begin
        // NOTE: registers are updated with <= so every flop samples the
        // pre-edge values; blocking = here would create order-dependent races.
        if (rst) begin
            // NOTE: every register here, including the edge-detect history,
            // is reset; there is no storage array that could be left out.
            state_q   <= IDLE;
            prev_q    <= '0;
            pending_q <= '0;
            operand_q <= '0;
            rr_q      <= '0;
            winner_q  <= '0;
            cnt_q     <= '0;
            led_q     <= OFFSET_C;
        end else begin
            state_q   <= state_d;
            prev_q    <= btn_s;
            pending_q <= pending_d;
            operand_q <= operand_d;
            rr_q      <= rr_d;
            winner_q  <= winner_d;
            cnt_q     <= cnt_d;
            led_q     <= led_d;
        end
    end

`ifdef BTN_SYNC_EN
    logic [NUM_REQ-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous button inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    assign btn_s = sync2_q;
`else
    assign btn_s = btn;
`endif

    assign led  = led_q;
    assign busy = (state_q != IDLE);

endmodule
